keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad through user GPIO pads; it is the input-side counterpart of the seven-segment display driver, which only writes pads.
- Drives one column low at a time, open-drain style, and samples the pulled-up rows.
- Debounces the full 16-key matrix and emits one code per debounced new press on a valid/ready interface.
- Instantiated beside the display logic inside the user project; columns map to io_out/io_oeb and rows map to io_in.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell). Legal range ≥4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required before the matrix is accepted. Legal range 1..15.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  scanning enable
- row_i  in  4  keypad rows from io_in, externally pulled up, low = pressed on the driven column
- col_o  out  4  column data to io_out, constant 0
- col_oeb_o  out  4  column output enables to io_oeb, active-low; 0 only on the driven column
- key_valid_o  out  1  key event available
- key_code_o  out  4  key code = col*4 + row
- key_ready_i  in  1  consumer accepts the event
- overflow_o  out  1  sticky flag: an event was dropped
- clear_i  in  1  clears overflow_o

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is asynchronous, active-low, on wb_rst_ni.
- Reset values:
  - col_oeb_o = 4'hF, col_o = 4'h0.
  - key_valid_o = 0, key_code_o = 0, overflow_o = 0.
  - Divider = 0, column index = 0, debounce count = 0, prev/stable matrices = 0.
  - Reset takes effect immediately, mid-scan included.
- Row synchronizer: row_i passes through a 2-flop synchronizer. The bench's effective input is row_i as seen 2 cycles earlier.
- Scan:
  - Divider counts 0..SCAN_DIV-1 while enable_i=1.
  - col_oeb_o = ~(1<<col).
  - At divider == SCAN_DIV-1, capture inverted synced rows into raw[col*4 +: 4], then advance col 0→1→2→3→0.
  - One full scan = 4*SCAN_DIV cycles; it ends on the capture of column 3.
- Debounce, evaluated at scan end:
  - If raw == prev: count = min(count+1, DEBOUNCE_SCANS). Otherwise count = 0.
  - prev := raw.
  - When the updated count == DEBOUNCE_SCANS: new_stable := raw, and new = new_stable & ~stable.
  - Latency: a key first present in scan k is accepted at the end of scan k+DEBOUNCE_SCANS.
- Event generation:
  - If new != 0, the event code is the lowest set bit index of new.
  - Any additional bits set in new are dropped and set overflow_o.
  - Release transitions produce no event.
  - A held key produces exactly one event.
- Output handshake:
  - An event loads key_code_o and sets key_valid_o on the next clock, if key_valid_o=0 or key_ready_i=1 in the event cycle.
  - Otherwise the event is dropped, overflow_o=1, and the held code is unchanged.
  - key_valid_o and key_code_o stay stable until a cycle with key_ready_i=1. key_valid_o then falls, unless a new event loads in that same cycle.
- overflow_o:
  - Cleared by clear_i.
  - If a set and clear_i occur in the same cycle, set wins.
- enable_i = 0:
  - Divider and column are held at 0; col_oeb_o = 4'hF.
  - raw, prev, stable and count are cleared.
  - Pending key_valid_o and key_code_o are unaffected.
  - Re-enabling starts column 0 with divider 0.
  - Keys held across re-enable are reported again after debounce.

Test Plan (SCAN_DIV=8, DEBOUNCE_SCANS=2; one scan = 32 cycles):
- Reset: assert wb_rst_ni=0 mid-scan → col_oeb_o=F and key_valid_o=0, overflow_o=0 immediately; after release with enable_i=1 → col_oeb_o=E for 8 cycles, then D, B, 7, and wraps back to E.
- Single press: model a key at row1/col2 (row_i[1]=0 whenever col_oeb_o=B) → key_valid_o=1 with key_code_o=9 after debounce; pulse key_ready_i for one cycle → valid drops the next cycle; no repeat while held; release then re-press → second event with code 9.
- Bounce: present the key in alternating scans only → count never reaches 2, key_valid_o stays 0.
- Overflow: hold key_ready_i=0, press code 0, release, then press code 15 → key_code_o stays 0, overflow_o=1; assert clear_i → overflow_o=0; assert ready → valid drops.
- Simultaneous press: codes 3 and 12 appear in the same scan → key_code_o=3, overflow_o=1, no later event for 12 while it is held.
- Disable: drop enable_i mid-column while a key is held → col_oeb_o=F on the next cycle and pending valid is retained; re-enable → scanning restarts at E, and the held key is re-reported after 3 scans.

Source files
------------

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner for user GPIO pads. Drives one
//                column low at a time (open-drain via output enables),
//                samples the pulled-up rows through a 2-flop synchronizer,
//                debounces the whole matrix and emits one code per new press
//                on a valid/ready interface, with a sticky drop flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_ni,
   input  logic       enable_i,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic [3:0] col_oeb_o,
   output logic       key_valid_o,
   output logic [3:0] key_code_o,
   input  logic       key_ready_i,
   output logic       overflow_o,
   input  logic       clear_i
);

   localparam int                 c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]         c_DEB      = 4'(DEBOUNCE_SCANS);

   logic [3:0]         r_row_meta;
   logic [3:0]         r_row_sync;
   logic               r_active;
   logic [c_DIV_W-1:0] r_div;
   logic [1:0]         r_col;
   logic [15:0]        r_raw;
   logic [15:0]        r_prev;
   logic [15:0]        r_stable;
   logic [3:0]         r_count;
   logic               r_key_valid;
   logic [3:0]         r_key_code;
   logic               r_overflow;

   logic               w_capture;
   logic               w_scan_end;
   logic [15:0]        w_raw_next;
   logic [3:0]         w_count_next;
   logic               w_accept;
   logic [15:0]        w_new;
   logic               w_evt;
   logic               w_multi;
   logic [3:0]         w_evt_code;
   logic               w_load;
   logic               w_ovf_set;

   // Columns are never driven high: the pad only switches between low and
   // released, so the pull-ups define the idle level.
   assign col_o       = 4'h0;
   // r_active delays the first driven column by one cycle after enable so the
   // column always gets a full dwell starting from divider 0.
   assign col_oeb_o   = r_active ? ~(4'b0001 << r_col) : 4'hF;
   assign key_valid_o = r_key_valid;
   assign key_code_o  = r_key_code;
   assign overflow_o  = r_overflow;

   assign w_capture  = r_active && enable_i && (r_div == c_DIV_LAST);
   assign w_scan_end = w_capture && (r_col == 2'd3);

   // Two-flop synchronizer on the asynchronous row pads (idle level is high).
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_row_meta <= 4'hF;
         r_row_sync <= 4'hF;
      end else begin
         r_row_meta <= row_i;
         r_row_sync <= r_row_meta;
      end
   end

   // Column dwell divider and column index; both parked at 0 while disabled.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_active <= 1'b0;
         r_div    <= '0;
         r_col    <= 2'd0;
      end else if (!enable_i) begin
         r_active <= 1'b0;
         r_div    <= '0;
         r_col    <= 2'd0;
      end else begin
         r_active <= 1'b1;
         if (r_active) begin
            if (r_div == c_DIV_LAST) begin
               r_div <= '0;
               r_col <= r_col + 2'd1;
            end else begin
               r_div <= r_div + 1'b1;
            end
         end
      end
   end

   // Raw matrix including the column captured this cycle (active-high keys).
   always_comb begin
      w_raw_next = r_raw;
      if (w_capture) begin
         w_raw_next[{r_col, 2'b00} +: 4] = ~r_row_sync;
      end
   end

   // Debounce: count consecutive identical scans, saturating at the target.
   always_comb begin
      w_count_next = 4'd0;
      if (w_raw_next == r_prev) begin
         w_count_next = (r_count >= c_DEB) ? c_DEB : (r_count + 4'd1);
      end
   end

   assign w_accept = w_scan_end && (w_count_next == c_DEB);
   assign w_new    = w_accept ? (w_raw_next & ~r_stable) : 16'h0000;
   assign w_evt    = |w_new;
   // More than one newly pressed key: only the lowest is reported.
   assign w_multi  = |(w_new & (w_new - 16'd1));

   // Lowest set bit of the new-press vector wins.
   always_comb begin
      w_evt_code = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (w_new[i]) begin
            w_evt_code = 4'(i);
         end
      end
   end

   assign w_load    = w_evt && (!r_key_valid || key_ready_i);
   assign w_ovf_set = (w_evt && !w_load) || w_multi;

   // Raw / previous / stable matrices and the debounce counter.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_raw    <= 16'h0000;
         r_prev   <= 16'h0000;
         r_stable <= 16'h0000;
         r_count  <= 4'd0;
      end else if (!enable_i) begin
         r_raw    <= 16'h0000;
         r_prev   <= 16'h0000;
         r_stable <= 16'h0000;
         r_count  <= 4'd0;
      end else begin
         if (w_capture) begin
            r_raw <= w_raw_next;
         end
         if (w_scan_end) begin
            r_prev  <= w_raw_next;
            r_count <= w_count_next;
            if (w_accept) begin
               r_stable <= w_raw_next;
            end
         end
      end
   end

   // Output holding register: load on event when free or being drained.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
      end else if (w_load) begin
         r_key_valid <= 1'b1;
         r_key_code  <= w_evt_code;
      end else if (key_ready_i) begin
         r_key_valid <= 1'b0;
      end
   end

   // Sticky drop flag; a new drop takes priority over a clear request.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_overflow <= 1'b0;
      end else if (w_ovf_set) begin
         r_overflow <= 1'b1;
      end else if (clear_i) begin
         r_overflow <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Directed self-checking bench for keypad_scanner with a
//                behavioural 4x4 key matrix (SCAN_DIV=8, DEBOUNCE_SCANS=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

   localparam int c_SCAN = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  col_oeb;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ready;
   logic        overflow;
   logic        clear;
   logic [15:0] pressed;

   int cyc  = 0;
   int base = 0;
   int n_vec = 0;
   int n_err = 0;

   keypad_scanner #(
      .SCAN_DIV       (8),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .enable_i    (enable),
      .row_i       (row),
      .col_o       (col),
      .col_oeb_o   (col_oeb),
      .key_valid_o (key_valid),
      .key_code_o  (key_code),
      .key_ready_i (key_ready),
      .overflow_o  (overflow),
      .clear_i     (clear)
   );

   always #5 clk = ~clk;

   // Free-running edge counter used to find scan boundaries.
   always @(posedge clk) cyc <= cyc + 1;

   // Key matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (col_oeb[c] == 1'b0) begin
            for (int r = 0; r < 4; r++) begin
               if (pressed[c*4 + r]) row[r] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   // Stop just after the edge that starts column 0 of a scan.
   task align;
      do tick; while (((cyc - base) % c_SCAN) != 1);
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!key_valid && n < limit) begin
         tick;
         n++;
      end
   endtask

   task automatic watch(input int cycles, output int seen);
      seen = 0;
      repeat (cycles) begin
         tick;
         if (key_valid) seen++;
      end
   endtask

   task ack;
      key_ready = 1'b1;
      tick;
      key_ready = 1'b0;
   endtask

   task clr;
      clear = 1'b1;
      tick;
      clear = 1'b0;
   endtask

   // Directed sequence: reset, column walk, press, bounce, overflow,
   // simultaneous press, disable/re-enable, reset mid-scan.
   initial begin
      int n;
      int seen;
      rst_n     = 1'b1;
      enable    = 1'b1;
      key_ready = 1'b0;
      clear     = 1'b0;
      pressed   = 16'h0000;
      #2 rst_n  = 1'b0;
      tick;
      tick;
      check("rst_oeb",   col_oeb,   4'hF);
      check("rst_col",   col,       4'h0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code",  key_code,  4'h0);
      check("rst_ovf",   overflow,  1'b0);

      rst_n = 1'b1;
      base  = cyc;
      for (int i = 1; i <= 33; i++) begin
         logic [3:0] exp_oeb;
         exp_oeb = ~(4'b0001 << (((i - 1) / 8) % 4));
         tick;
         check("scan_oeb", col_oeb, exp_oeb);
      end

      // Single press of code 9 (row1/col2).
      align;
      pressed = 16'h0200;
      wait_valid(300, n);
      check("p1_lat",   n,        96);
      check("p1_code",  key_code, 4'd9);
      repeat (3) tick;
      check("p1_hold",  key_valid, 1'b1);
      ack;
      check("p1_drop",  key_valid, 1'b0);
      watch(128, seen);
      check("p1_norep", seen, 0);
      pressed = 16'h0000;
      watch(128, seen);
      check("p1_rel",   seen, 0);
      align;
      pressed = 16'h0200;
      wait_valid(300, n);
      check("p2_lat",   n,        96);
      check("p2_code",  key_code, 4'd9);
      ack;
      pressed = 16'h0000;
      watch(128, seen);

      // Bounce: key present on alternate scans only.
      align;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         int s;
         pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
         watch(c_SCAN, s);
         seen += s;
      end
      check("bounce", seen, 0);
      pressed = 16'h0000;
      watch(128, seen);

      // Overflow: code 0 pending, then code 15 arrives while not ready.
      align;
      pressed = 16'h0001;
      wait_valid(300, n);
      check("o_lat",  n,        96);
      check("o_code", key_code, 4'd0);
      pressed = 16'h0000;
      watch(128, seen);
      align;
      pressed = 16'h8000;
      repeat (95) tick;
      check("o_pre",   overflow,  1'b0);
      tick;
      check("o_set",   overflow,  1'b1);
      check("o_keep",  key_code,  4'd0);
      check("o_valid", key_valid, 1'b1);
      clr;
      check("o_clr",   overflow,  1'b0);
      ack;
      check("o_ack",   key_valid, 1'b0);
      pressed = 16'h0000;
      watch(128, seen);

      // Simultaneous press of codes 3 and 12.
      align;
      pressed = 16'h1008;
      wait_valid(300, n);
      check("s_lat",  n,        96);
      check("s_code", key_code, 4'd3);
      check("s_ovf",  overflow, 1'b1);
      ack;
      clr;
      check("s_clr",  overflow, 1'b0);
      watch(128, seen);
      check("s_norep", seen,    0);
      check("s_ovf2",  overflow, 1'b0);
      pressed = 16'h0000;
      watch(128, seen);

      // Disable mid-column with an event pending, then re-enable.
      align;
      pressed = 16'h0020;
      wait_valid(300, n);
      check("d_lat",  n,        96);
      check("d_code", key_code, 4'd5);
      repeat (3) tick;
      enable = 1'b0;
      tick;
      check("d_oeb",   col_oeb,   4'hF);
      check("d_valid", key_valid, 1'b1);
      repeat (10) tick;
      check("d_oeb2",  col_oeb,   4'hF);
      check("d_code2", key_code,  4'd5);
      enable = 1'b1;
      base   = cyc;
      tick;
      check("d_re_oeb", col_oeb, 4'hE);
      ack;
      check("d_ack", key_valid, 1'b0);
      wait_valid(300, n);
      check("d_relat", n + 2,    97);
      check("d_recode", key_code, 4'd5);

      // Drop with event pending, then asynchronous reset mid-cycle.
      align;
      pressed = 16'h0420;
      repeat (96) tick;
      check("r_ovf",  overflow, 1'b1);
      check("r_code", key_code, 4'd5);
      #3 rst_n = 1'b0;
      #1;
      check("r_oeb",   col_oeb,   4'hF);
      check("r_valid", key_valid, 1'b0);
      check("r_ovf0",  overflow,  1'b0);
      check("r_code0", key_code,  4'd0);
      pressed = 16'h0000;
      tick;
      rst_n = 1'b1;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
